// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - if_state_t : 2-bit state encoding S_FETCH, S_KILL, S_HOLD, S_ERR
//   - INSTR_NOP  : bubble instruction word (all zeros)
//   - if2id_t    : layout of the IF -> ID interstage bundle
//                  {instr[31:0], next_pc[31:0]}
package stage_if_pkg;

    localparam int          IF2ID_WIRE_WIDTH = 64;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_KILL  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } if_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] next_pc;
    } if2id_t;

endpackage

// File: rtl/stage_if.sv
// Instruction fetch stage.
// Owns the PC, fetches from instruction memory over a req/ack handshake,
// applies redirects from later stages, honours downstream stall and feeds
// the decode stage through a registered if2id bundle. A NOP bubble
// (instr = 0, next_pc = current pc) is emitted whenever nothing is delivered.
//
// Ports:
//   clk              system clock, all state on posedge
//   rst              synchronous active-low reset
//   stall            downstream not accepting; interstage_if2id holds
//   redirect_en      one-cycle pulse: replace PC with redirect_pc
//   redirect_pc      new fetch address
//   imem_req         fetch request, held until imem_ack
//   imem_addr        fetch address (the pc register)
//   imem_ack         one-cycle pulse, imem_rdata valid in the same cycle
//   imem_rdata       fetched instruction word
//   interstage_if2id registered {instr, next_pc}
//   fetch_exc        misaligned-redirect flag (only with IF_MISALIGN_CHK_EN)
//
// Build option: define IF_MISALIGN_CHK_EN to trap redirects whose low two
// address bits are non-zero into S_ERR and expose fetch_exc.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        redirect_en,
    input  logic [31:0]                 redirect_pc,
    output logic                        imem_req,
    output logic [31:0]                 imem_addr,
    input  logic                        imem_ack,
    input  logic [31:0]                 imem_rdata,
    output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic                        fetch_exc
`endif
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] pending_q, pending_d;
    logic        req_q, req_d;
    if2id_t      out_q, out_d;

    logic [31:0] pc_plus4;
    logic        ack_eff;
    logic        redirect_bad;
    logic        pending_bad;
    logic        kill_bad;
    logic [31:0] kill_target;

    assign pc_plus4 = pc_q + 32'd4;

    // An ack only counts while a request is actually outstanding, so a
    // late ack arriving after reset is ignored.
    assign ack_eff = imem_ack & req_q;

`ifdef IF_MISALIGN_CHK_EN
    assign redirect_bad = |redirect_pc[1:0];
    assign pending_bad  = |pending_q[1:0];
    assign fetch_exc    = (state_q == S_ERR);
`else
    assign redirect_bad = 1'b0;
    assign pending_bad  = 1'b0;
`endif

    // When a killed fetch finally acks, a redirect in that same cycle wins
    // over the one parked in pending.
    assign kill_target = redirect_en ? redirect_pc  : pending_q;
    assign kill_bad    = redirect_en ? redirect_bad : pending_bad;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        out_d     = stall ? out_q : '{instr: INSTR_NOP, next_pc: pc_q};

        unique case (state_q)
            S_FETCH: begin
                // Without an outstanding request (first cycle after reset)
                // a redirect can be taken at once; otherwise the request
                // cannot be withdrawn and the redirect is parked in S_KILL.
                if (redirect_en && (ack_eff || !req_q)) begin
                    state_d = redirect_bad ? S_ERR : S_FETCH;
                    pc_d    = redirect_bad ? pc_q  : redirect_pc;
                end else if (redirect_en) begin
                    pending_d = redirect_pc;
                    state_d   = S_KILL;
                end else if (ack_eff) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        out_d = '{instr: imem_rdata, next_pc: pc_plus4};
                        pc_d  = pc_plus4;
                    end
                end
            end
            S_KILL: begin
                if (redirect_en) begin
                    pending_d = redirect_pc;
                end
                if (ack_eff) begin
                    state_d = kill_bad ? S_ERR : S_FETCH;
                    pc_d    = kill_bad ? pc_q  : kill_target;
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    state_d = redirect_bad ? S_ERR : S_FETCH;
                    pc_d    = redirect_bad ? pc_q  : redirect_pc;
                end else if (!stall) begin
                    out_d   = '{instr: hold_q, next_pc: pc_plus4};
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
`ifdef IF_MISALIGN_CHK_EN
            S_ERR: begin
                if (redirect_en && !redirect_bad) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        req_d = (state_d == S_FETCH) || (state_d == S_KILL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            hold_q    <= 32'h0;
            pending_q <= 32'h0;
            req_q     <= 1'b0;
            out_q     <= '{instr: INSTR_NOP, next_pc: RESET_PC};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            out_q     <= out_d;
        end
    end

    assign imem_req         = req_q;
    assign imem_addr        = pc_q;
    assign interstage_if2id = out_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if with a behavioural instruction memory of
// configurable latency. Each scenario task applies stimulus and compares
// observed outputs against hand-computed values.
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id;
`ifdef IF_MISALIGN_CHK_EN
    logic        fetch_exc;
`endif

    logic [31:0] out_instr;
    logic [31:0] out_next_pc;
    assign {out_instr, out_next_pc} = interstage_if2id;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 1;
    int mem_cnt = 0;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .interstage_if2id (interstage_if2id)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .fetch_exc        (fetch_exc)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: three known words at 0/4/8, otherwise addr + 0x1000_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return a + 32'h1000_0000;
        endcase
    endfunction

    // Memory responder: acks in the mem_lat-th cycle a request is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    mem_cnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                end
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst         = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        mem_lat     = lat;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset(1);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req: got %0b expected 0", imem_req);
        end
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr);
        end
        vectors++;
        if (interstage_if2id !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got %h expected 0", interstage_if2id);
        end
`ifdef IF_MISALIGN_CHK_EN
        vectors++;
        if (fetch_exc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_exc: got %0b expected 0", fetch_exc);
        end
`endif
        rst = 1'b1;
        tick();
        vectors++;
        if (imem_req !== 1'b1 || interstage_if2id !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: req %0b out %h expected req 1 out 0",
                     imem_req, interstage_if2id);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h11;
        exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33;
        do_reset(1);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (imem_addr !== 32'(4 * i)) begin
                miscompares++;
                $display("[TB] FAIL stream_addr%0d: got %h expected %h", i, imem_addr, 4 * i);
            end
            tick();
            vectors++;
            if (out_instr !== exp_instr[i] || out_next_pc !== 32'(4 * i + 4)) begin
                miscompares++;
                $display("[TB] FAIL stream_out%0d: got %h/%h expected %h/%h",
                         i, out_instr, out_next_pc, exp_instr[i], 4 * i + 4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        rst = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out_instr !== 32'h11 || out_next_pc !== 32'h4 || imem_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: got %h/%h req %0b expected 00000011/00000004 req 0",
                         i, out_instr, out_next_pc, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        vectors++;
        if (out_instr !== 32'h22 || out_next_pc !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got %h/%h req %0b addr %h expected 00000022/00000008 req 1 addr 8",
                     out_instr, out_next_pc, imem_req, imem_addr);
        end
        tick();
        vectors++;
        if (out_instr !== 32'h33 || out_next_pc !== 32'hC) begin
            miscompares++;
            $display("[TB] FAIL stall_after: got %h/%h expected 00000033/0000000c",
                     out_instr, out_next_pc);
        end
    endtask

    task automatic test_redirect_kill();
        do_reset(1);
        rst = 1'b1;
        tick();
        tick();
        tick();
        mem_lat = 3;
        tick();
        vectors++;
        if (out_instr !== 32'h0 || out_next_pc !== 32'h8 || imem_addr !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL kill_bubble0: got %h/%h addr %h expected 0/8 addr 8",
                     out_instr, out_next_pc, imem_addr);
        end
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_instr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL kill_req_held: req %0b addr %h instr %h expected req 1 addr 8 instr 0",
                     imem_req, imem_addr, out_instr);
        end
        tick();
        vectors++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1 || out_instr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL kill_drop: addr %h req %0b instr %h expected addr 100 req 1 instr 0",
                     imem_addr, imem_req, out_instr);
        end
        tick();
        tick();
        vectors++;
        if (out_instr !== 32'h0 || out_next_pc !== 32'h100) begin
            miscompares++;
            $display("[TB] FAIL kill_bubble1: got %h/%h expected 0/100", out_instr, out_next_pc);
        end
        tick();
        vectors++;
        if (out_instr !== 32'h1000_0100 || out_next_pc !== 32'h104) begin
            miscompares++;
            $display("[TB] FAIL kill_newfetch: got %h/%h expected 10000100/00000104",
                     out_instr, out_next_pc);
        end
    endtask

    task automatic test_redirect_ack_stall();
        do_reset(1);
        rst = 1'b1;
        tick();
        tick();
        stall       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        tick();
        stall       = 1'b0;
        redirect_en = 1'b0;
        vectors++;
        if (out_instr !== 32'h11 || out_next_pc !== 32'h4 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL redir_stall: got %h/%h addr %h req %0b expected 00000011/00000004 addr 200 req 1",
                     out_instr, out_next_pc, imem_addr, imem_req);
        end
        tick();
        vectors++;
        if (out_instr !== 32'h1000_0200 || out_next_pc !== 32'h204) begin
            miscompares++;
            $display("[TB] FAIL redir_stall_next: got %h/%h expected 10000200/00000204",
                     out_instr, out_next_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        rst = 1'b1;
        tick();
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC || out_instr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wrap_redir: addr %h instr %h expected fffffffc instr 0",
                     imem_addr, out_instr);
        end
        tick();
        vectors++;
        if (out_instr !== 32'h0FFF_FFFC || out_next_pc !== 32'h0 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wrap_pc: got %h/%h addr %h expected 0ffffffc/00000000 addr 0",
                     out_instr, out_next_pc, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || interstage_if2id !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset: req %0b addr %h out %h expected req 0 addr 0 out 0",
                     imem_req, imem_addr, interstage_if2id);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (out_instr !== 32'h11 || out_next_pc !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL midreset_refetch: got %h/%h expected 00000011/00000004",
                     out_instr, out_next_pc);
        end
    endtask

`ifdef IF_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset(1);
        rst = 1'b1;
        tick();
        redirect_en = 1'b1;
        redirect_pc = 32'h102;
        tick();
        vectors++;
        if (fetch_exc !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL misalign_err: exc %0b req %0b expected exc 1 req 0", fetch_exc, imem_req);
        end
        redirect_pc = 32'h104;
        tick();
        redirect_en = 1'b0;
        vectors++;
        if (fetch_exc !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            miscompares++;
            $display("[TB] FAIL misalign_recover: exc %0b req %0b addr %h expected exc 0 req 1 addr 104",
                     fetch_exc, imem_req, imem_addr);
        end
    endtask
`endif

    initial begin
        $display("[TB] stage_if directed test start");
        test_reset();
        test_stream();
        test_stall();
        test_redirect_kill();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_mid();
`ifdef IF_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
